// File: rtl/up_down_counter_mod.sv
// rtl/up_down_counter_mod.sv - width-generic load/up/down counter with programmable limit, wrap/saturate and flags
// Optional macro UP_DOWN_COUNTER_MOD_OUT_REG_EN adds one output register stage on all outputs.
module up_down_counter_mod #(
    parameter int WIDTH       = 8,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             direction,
    input  logic             saturate,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             sat_hit
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_r;
    logic             sat_r;
    logic             wrap_nxt;
    logic             sat_nxt;
    logic             at_max_c;
    logic             at_zero_c;

    // Next-state selection: load beats counting; out-of-range counts (limit lowered) are pulled back into 0..limit.
    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (load) begin
            cnt_nxt = (data_in > limit) ? limit : data_in;
        end else if (en) begin
            if (limit == ZERO) begin
                // Degenerate range: every step hits a bound.
                cnt_nxt  = ZERO;
                wrap_nxt = ~saturate;
                sat_nxt  = saturate;
            end else if (direction) begin
                if (cnt >= limit) begin
                    cnt_nxt  = saturate ? limit : ZERO;
                    wrap_nxt = ~saturate;
                    sat_nxt  = saturate;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end else begin
                if (cnt == ZERO) begin
                    cnt_nxt  = saturate ? ZERO : limit;
                    wrap_nxt = ~saturate;
                    sat_nxt  = saturate;
                end else if (cnt > limit) begin
                    cnt_nxt = limit;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
        end
    end

    // Count and event-pulse state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= RST_CNT;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            wrap_r <= wrap_nxt;
            sat_r  <= sat_nxt;
        end
    end

    // Level flags compare the state against the live limit input.
    always_comb begin
        at_max_c  = (cnt == limit);
        at_zero_c = (cnt == ZERO);
    end

`ifdef UP_DOWN_COUNTER_MOD_OUT_REG_EN
    logic [WIDTH-1:0] count_q;
    logic             at_max_q;
    logic             at_zero_q;
    logic             wrap_q;
    logic             sat_hit_q;

    // Legacy-timing output stage; reset loads it directly so outputs reflect reset on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= RST_CNT;
            at_max_q  <= (RST_CNT == limit);
            at_zero_q <= (RST_CNT == ZERO);
            wrap_q    <= 1'b0;
            sat_hit_q <= 1'b0;
        end else begin
            count_q   <= cnt;
            at_max_q  <= at_max_c;
            at_zero_q <= at_zero_c;
            wrap_q    <= wrap_r;
            sat_hit_q <= sat_r;
        end
    end

    assign count   = count_q;
    assign at_max  = at_max_q;
    assign at_zero = at_zero_q;
    assign wrap    = wrap_q;
    assign sat_hit = sat_hit_q;
`else
    assign count   = cnt;
    assign at_max  = at_max_c;
    assign at_zero = at_zero_c;
    assign wrap    = wrap_r;
    assign sat_hit = sat_r;
`endif

endmodule

// File: tb/tb_up_down_counter_mod.sv
// tb/tb_up_down_counter_mod.sv - scoreboard testbench for up_down_counter_mod
module tb_up_down_counter_mod;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] RV = 8'd0;

    logic             clk;
    logic             reset;
    logic             en;
    logic             load;
    logic             direction;
    logic             saturate;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             wrap;
    logic             sat_hit;

    int n_cmp  = 0;
    int n_fail = 0;

    // expected {count, at_max, at_zero, wrap, sat_hit}
    logic [WIDTH+3:0] sb[$];
    logic [WIDTH+3:0] got;
    logic [WIDTH+3:0] exp_v;

    // reference state
    logic [WIDTH-1:0] m_cnt = RV;
    logic             m_w   = 1'b0;
    logic             m_s   = 1'b0;
    logic [WIDTH-1:0] o_cnt = RV;
    logic             o_w   = 1'b0;
    logic             o_s   = 1'b0;

    up_down_counter_mod #(.WIDTH(WIDTH), .RESET_VALUE(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .direction (direction),
        .saturate  (saturate),
        .data_in   (data_in),
        .limit     (limit),
        .count     (count),
        .at_max    (at_max),
        .at_zero   (at_zero),
        .wrap      (wrap),
        .sat_hit   (sat_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge of stimulus, push the expected visible outputs, and return 1 time unit after the edge.
    task automatic step(input logic r, input logic ld, input logic e, input logic dir,
                        input logic sat, input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] lim);
        logic [WIDTH-1:0] n;
        logic             w;
        logic             s;
        logic [WIDTH-1:0] vis;
        @(negedge clk);
        reset = r; load = ld; en = e; direction = dir; saturate = sat; data_in = din; limit = lim;
        n = m_cnt; w = 1'b0; s = 1'b0;
        if (r) begin
            n = RV;
        end else if (ld) begin
            n = (din > lim) ? lim : din;
        end else if (e) begin
            if (lim == 0) begin
                n = 0; w = !sat; s = sat;
            end else if (dir) begin
                if (m_cnt == lim)      begin n = sat ? m_cnt : 8'd0; w = !sat; s = sat; end
                else if (m_cnt > lim)  begin n = sat ? lim : 8'd0;   w = !sat; s = sat; end
                else                   n = m_cnt + 8'd1;
            end else begin
                if (m_cnt == 0)        begin n = sat ? 8'd0 : lim;   w = !sat; s = sat; end
                else if (m_cnt > lim)  n = lim;
                else                   n = m_cnt - 8'd1;
            end
        end
`ifdef UP_DOWN_COUNTER_MOD_OUT_REG_EN
        if (r) begin
            o_cnt = RV; o_w = 1'b0; o_s = 1'b0;
        end else begin
            o_cnt = m_cnt; o_w = m_w; o_s = m_s;
        end
        m_cnt = n; m_w = w; m_s = s;
        vis = o_cnt;
        sb.push_back({vis, vis == lim, vis == 8'd0, o_w, o_s});
`else
        m_cnt = n; m_w = w; m_s = s;
        vis = m_cnt;
        sb.push_back({vis, vis == lim, vis == 8'd0, m_w, m_s});
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 1, 0, 8'd0, 8'd9);
        exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
        n_cmp++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_wrap_up();
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 1, 0, 8'd0, 8'd9);
            exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
            n_cmp++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_saturate_down();
        step(0, 1, 0, 0, 1, 8'd2, 8'd9);
        exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
        n_cmp++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL sat_down_load: got %h expected %h", got, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 1, 8'd0, 8'd9);
            exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
            n_cmp++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL sat_down[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_load_clamp();
        logic [WIDTH-1:0] din_tab[3];
        logic             en_tab[3];
        din_tab = '{8'd200, 8'd7, 8'd7};
        en_tab  = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(0, (i < 2), en_tab[i], 1, 0, din_tab[i], 8'd50);
            exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
            n_cmp++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL load_clamp[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_limit_drop();
        for (int m = 0; m < 2; m++) begin
            step(0, 1, 0, 1, m[0], 8'd40, 8'd100);
            step(0, 0, 1, 1, m[0], 8'd0, 8'd20);
            step(0, 0, 0, 1, m[0], 8'd0, 8'd20);
            for (int i = 0; i < 3; i++) begin
                exp_v = sb.pop_front();
                if (i == 2) begin
                    got = {count, at_max, at_zero, wrap, sat_hit};
                    n_cmp++;
                    if (got !== exp_v) begin
                        n_fail++;
                        $display("FAIL limit_drop[%0d]: got %h expected %h", m, got, exp_v);
                    end
                end
            end
        end
        // lowered limit while counting down also pulls the count into range
        step(0, 1, 0, 0, 0, 8'd40, 8'd100);
        step(0, 0, 1, 0, 0, 8'd0, 8'd20);
        step(0, 0, 0, 0, 0, 8'd0, 8'd20);
        for (int i = 0; i < 3; i++) begin
            exp_v = sb.pop_front();
            if (i == 2) begin
                got = {count, at_max, at_zero, wrap, sat_hit};
                n_cmp++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL limit_drop_down: got %h expected %h", got, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0, 1, 0, 8'd4, 8'd9);
        step(0, 0, 1, 1, 0, 8'd0, 8'd9);
        step(1, 1, 1, 1, 0, 8'd7, 8'd9);
        for (int i = 0; i < 3; i++) begin
            exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
            if (i == 2) begin
                n_cmp++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL reset_mid: got %h expected %h", got, exp_v);
                end
            end
        end
    endtask

    task automatic test_full_range();
        step(0, 1, 0, 1, 0, 8'd255, 8'd255);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(0, 0, (i == 1), 1, 0, 8'd0, 8'd255);
            exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
            n_cmp++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL full_range[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_limit_zero();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, i[0], i[1], 8'd0, 8'd0);
            exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
            n_cmp++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL limit_zero[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12)));
            exp_v = sb.pop_front(); got = {count, at_max, at_zero, wrap, sat_hit};
            n_cmp++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; direction = 1'b1; saturate = 1'b0;
        data_in = '0; limit = 8'd9;
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_load_clamp();
        test_limit_drop();
        test_reset_mid();
        test_full_range();
        test_limit_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
